// File: rtl/egress_read_scheduler.sv
// Per-output read scheduler for the shared-memory switch egress stage: round-robin source
// selection with a burst quota, gated by downstream tx_ready, plus an RD_LAT read-data tag pipe.
module egress_read_scheduler #(
    parameter int PORT_NUB  = 4,
    parameter int WIDTH_SEL = $clog2(PORT_NUB),
    parameter int BURST     = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [PORT_NUB*PORT_NUB-1:0]  empty,
    input  logic [PORT_NUB-1:0]           tx_ready,
    output logic [WIDTH_SEL*PORT_NUB-1:0] rd_sel,
    output logic [PORT_NUB-1:0]           rd_en,
    output logic [PORT_NUB-1:0]           out_vld,
    output logic [WIDTH_SEL*PORT_NUB-1:0] out_src,
    output logic                          busy,
    output logic [PORT_NUB-1:0]           fsm_state
);

    localparam int CNT_W = $clog2(BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t               state_q [PORT_NUB];
    state_t               state_d [PORT_NUB];
    logic [WIDTH_SEL-1:0] ptr_q   [PORT_NUB];
    logic [WIDTH_SEL-1:0] ptr_d   [PORT_NUB];
    logic [WIDTH_SEL-1:0] src_q   [PORT_NUB];
    logic [WIDTH_SEL-1:0] src_d   [PORT_NUB];
    logic [CNT_W-1:0]     cnt_q   [PORT_NUB];
    logic [CNT_W-1:0]     cnt_d   [PORT_NUB];

    logic [PORT_NUB-1:0]  emp     [PORT_NUB];
    logic [WIDTH_SEL-1:0] pick    [PORT_NUB];
    logic [WIDTH_SEL-1:0] idx;
    logic [PORT_NUB-1:0]  found;
    logic [PORT_NUB-1:0]  src_empty;
    logic [PORT_NUB-1:0]  leave;

    logic [RD_LAT-1:0]    pv_q    [PORT_NUB];
    logic [WIDTH_SEL-1:0] ps_q    [PORT_NUB][RD_LAT];

    for (genvar gi = 0; gi < PORT_NUB; gi++) begin : g_emp
        assign emp[gi] = empty[gi*PORT_NUB +: PORT_NUB];
    end

    // Round-robin search: the lowest offset from ptr that is non-empty wins.
    always_comb begin
        found = '0;
        idx   = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            pick[i] = '0;
            for (int k = PORT_NUB - 1; k >= 0; k--) begin
                idx = WIDTH_SEL'((int'(ptr_q[i]) + k) % PORT_NUB);
                if (!emp[i][idx]) begin
                    found[i] = 1'b1;
                    pick[i]  = idx;
                end
            end
        end
    end

    // Handshake: a cell moves when rd_en is high at an edge; tx_ready is the downstream
    // ready and gates rd_en combinationally in the same cycle, with no registered lag.
    always_comb begin
        rd_en     = '0;
        src_empty = '0;
        rd_sel    = '0;
        fsm_state = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            src_empty[i] = emp[i][src_q[i]];
            rd_en[i]     = (state_q[i] == SERVE) && en && tx_ready[i] && !src_empty[i];
            rd_sel[i*WIDTH_SEL +: WIDTH_SEL] = src_q[i];
            fsm_state[i] = (state_q[i] == SERVE);
        end
    end

    always_comb begin
        leave = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            state_d[i] = state_q[i];
            ptr_d[i]   = ptr_q[i];
            src_d[i]   = src_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (en && found[i]) begin
                        src_d[i]   = pick[i];
                        cnt_d[i]   = '0;
                        state_d[i] = SERVE;
                    end
                end
                SERVE: begin
                    if (en) begin
                        if (src_empty[i]) begin
                            leave[i] = 1'b1;
                        end else if (tx_ready[i]) begin
                            if (cnt_q[i] == CNT_W'(BURST - 1)) leave[i] = 1'b1;
                            else cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            // Leaving a source puts it at the back of the rotation.
            if (leave[i]) begin
                state_d[i] = IDLE;
                ptr_d[i]   = WIDTH_SEL'((int'(src_q[i]) + 1) % PORT_NUB);
                cnt_d[i]   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORT_NUB; i++) begin
                state_q[i] <= IDLE;
                ptr_q[i]   <= '0;
                src_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < PORT_NUB; i++) begin
                state_q[i] <= state_d[i];
                ptr_q[i]   <= ptr_d[i];
                src_q[i]   <= src_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Tag pipe matching the FIFO read latency; it keeps shifting while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORT_NUB; i++) begin
                pv_q[i] <= '0;
                for (int s = 0; s < RD_LAT; s++) ps_q[i][s] <= '0;
            end
        end else begin
            for (int i = 0; i < PORT_NUB; i++) begin
                pv_q[i][0] <= rd_en[i];
                ps_q[i][0] <= src_q[i];
                for (int s = 1; s < RD_LAT; s++) begin
                    pv_q[i][s] <= pv_q[i][s-1];
                    ps_q[i][s] <= ps_q[i][s-1];
                end
            end
        end
    end

    always_comb begin
        out_vld = '0;
        out_src = '0;
        busy    = 1'b0;
        for (int i = 0; i < PORT_NUB; i++) begin
            out_vld[i] = pv_q[i][RD_LAT-1];
            out_src[i*WIDTH_SEL +: WIDTH_SEL] = ps_q[i][RD_LAT-1];
            busy = busy | fsm_state[i] | (|pv_q[i]);
        end
    end

endmodule

// File: tb/tb_egress_read_scheduler.sv
// Directed bench for egress_read_scheduler: a FIFO occupancy model drives empty, and a
// scoreboard of expected {due_cycle, src} entries is checked by an out_vld monitor.
module tb_egress_read_scheduler;

    localparam int N      = 4;
    localparam int WS     = 2;
    localparam int RD_LAT = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N*N-1:0]  empty_s;
    logic [N-1:0]    tx_ready;
    logic [WS*N-1:0] rd_sel;
    logic [N-1:0]    rd_en;
    logic [N-1:0]    out_vld;
    logic [WS*N-1:0] out_src;
    logic            busy;
    logic [N-1:0]    fsm_state;

    int          fifo_cnt [N][N];
    logic [N-1:0]    tk_en  = '0;
    logic [WS*N-1:0] tk_sel = '0;
    int          cyc_n  = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [33:0] exp_q [N][$];
    logic [33:0] mon_e;

    egress_read_scheduler #(
        .PORT_NUB (N),
        .WIDTH_SEL(WS),
        .BURST    (4),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .empty    (empty_s),
        .tx_ready (tx_ready),
        .rd_sel   (rd_sel),
        .rd_en    (rd_en),
        .out_vld  (out_vld),
        .out_src  (out_src),
        .busy     (busy),
        .fsm_state(fsm_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always_comb begin
        empty_s = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                empty_s[i*N + j] = (fifo_cnt[i][j] == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // Advance one cycle; reads sampled at the last negedge drain the FIFO model.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (tk_en[i]) begin
                if (fifo_cnt[i][tk_sel[2*i +: 2]] == 0)
                    check($sformatf("read of empty fifo out%0d", i), 32'(tk_en[i]), 32'd0);
                else
                    fifo_cnt[i][tk_sel[2*i +: 2]]--;
            end
        end
        #1;
    endtask

    task automatic chk_rd(input int o, input logic e, input logic [1:0] s, input logic push);
        logic [N-1:0]  m;
        logic [31:0]   due;
        #1;
        m = 4'b0001 << o;
        check($sformatf("rd_en[%0d]", o), 32'(rd_en[o]), 32'(e));
        check($sformatf("rd_en others of %0d", o), 32'(rd_en & ~m), 32'd0);
        if (e) begin
            check($sformatf("rd_sel[%0d]", o), 32'(rd_sel[2*o +: 2]), 32'(s));
            if (push) begin
                due = cyc_n + RD_LAT;
                exp_q[o].push_back({due, s});
            end
        end
    endtask

    task automatic run_pat(input int o, input int n, input logic [31:0] en_pat,
                           input logic [63:0] sel_pat);
        for (int c = 0; c < n; c++) begin
            if (c > 0) step();
            chk_rd(o, en_pat[c], sel_pat[2*c +: 2], 1'b1);
        end
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, " rd_en"},     32'(rd_en),     32'd0);
        check({tag, " rd_sel"},    32'(rd_sel),    32'd0);
        check({tag, " out_vld"},   32'(out_vld),   32'd0);
        check({tag, " out_src"},   32'(out_src),   32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " fsm_state"}, 32'(fsm_state), 32'd0);
    endtask

    // Monitor: sample reads for the FIFO model and score every out_vld beat.
    always @(negedge clk) begin
        tk_en  = rd_en;
        tk_sel = rd_sel;
        for (int i = 0; i < N; i++) begin
            if (out_vld[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("out_vld unexpected [%0d]", i), 32'(out_vld[i]), 32'd0);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    check($sformatf("out_src[%0d]", i), 32'(out_src[2*i +: 2]), 32'(mon_e[1:0]));
                    check($sformatf("out_vld cycle[%0d]", i), cyc_n, mon_e[33:2]);
                end
            end else if (exp_q[i].size() > 0 && int'(exp_q[i][0][33:2]) <= cyc_n) begin
                mon_e = exp_q[i].pop_front();
                check($sformatf("out_vld missing [%0d]", i), 32'(out_vld[i]), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    // Driver: directed vectors
    initial begin
        logic [1:0] seq [6];
        seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                fifo_cnt[i][j] = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        tx_ready = '1;

        step();
        #1;
        chk_quiet("reset");
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            #1;
            check("idle rd_en",     32'(rd_en),     32'd0);
            check("idle out_vld",   32'(out_vld),   32'd0);
            check("idle busy",      32'(busy),      32'd0);
            check("idle fsm_state", 32'(fsm_state), 32'd0);
        end

        // Output 0, source 2 with 6 cells: 4-read burst, bubble, 2 reads
        step();
        fifo_cnt[0][2] = 6;
        run_pat(0, 10, 32'h0DE, 64'hAAAA_AAAA_AAAA_AAAA);
        // ptr now 3: source 3 wins over source 0, then ptr wraps to 0
        step();
        fifo_cnt[0][0] = 1;
        fifo_cnt[0][3] = 1;
        run_pat(0, 7, 32'h12, 64'hC);

        // Output 1, sources 0,1,3 with 8 cells: rotation 0,1,3,0,1,3
        step();
        fifo_cnt[1][0] = 8;
        fifo_cnt[1][1] = 8;
        fifo_cnt[1][3] = 8;
        for (int b = 0; b < 6; b++) begin
            if (b > 0) step();
            chk_rd(1, 1'b0, 2'd0, 1'b1);
            for (int r = 0; r < 4; r++) begin
                step();
                chk_rd(1, 1'b1, seq[b], 1'b1);
            end
        end
        step();
        chk_rd(1, 1'b0, 2'd0, 1'b1);
        step();
        chk_rd(1, 1'b0, 2'd0, 1'b1);

        // Output 2, source 1 with 3 cells, tx_ready 1,0,0,1,1
        step();
        fifo_cnt[2][1] = 3;
        chk_rd(2, 1'b0, 2'd0, 1'b1);
        step();
        chk_rd(2, 1'b1, 2'd1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            step();
            tx_ready[2] = 1'b0;
            chk_rd(2, 1'b0, 2'd0, 1'b1);
            check("stall holds SERVE", 32'(fsm_state[2]), 32'd1);
        end
        step();
        tx_ready[2] = 1'b1;
        chk_rd(2, 1'b1, 2'd1, 1'b1);
        step();
        chk_rd(2, 1'b1, 2'd1, 1'b1);
        step();
        chk_rd(2, 1'b0, 2'd0, 1'b1);
        check("empty exit pending", 32'(fsm_state[2]), 32'd1);
        step();
        chk_rd(2, 1'b0, 2'd0, 1'b1);
        check("empty exit done", 32'(fsm_state[2]), 32'd0);
        // ptr now 2: source 2 first, then search 3,0,1 finds 1
        step();
        fifo_cnt[2][1] = 1;
        fifo_cnt[2][2] = 1;
        run_pat(2, 7, 32'h12, 64'h108);

        // Output 3 reset mid-burst with a read in the pipeline
        step();
        fifo_cnt[3][0] = 8;
        chk_rd(3, 1'b0, 2'd0, 1'b1);
        step();
        chk_rd(3, 1'b1, 2'd0, 1'b1);
        step();
        chk_rd(3, 1'b1, 2'd0, 1'b0);
        step();
        chk_rd(3, 1'b1, 2'd0, 1'b0);
        check("pipeline holds read", 32'(out_vld[3]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("async reset");
        fifo_cnt[3][0] = 0;
        step();
        step();
        #1;
        chk_quiet("reset held");
        step();
        rst_n = 1'b1;
        fifo_cnt[2][0] = 1;
        fifo_cnt[2][3] = 1;
        run_pat(2, 7, 32'h12, 64'h300);

        // Output 0, en low for 3 cycles mid-burst
        step();
        fifo_cnt[0][1] = 4;
        chk_rd(0, 1'b0, 2'd0, 1'b1);
        step();
        chk_rd(0, 1'b1, 2'd1, 1'b1);
        step();
        chk_rd(0, 1'b1, 2'd1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            en = 1'b0;
            chk_rd(0, 1'b0, 2'd0, 1'b1);
            check("en low holds SERVE", 32'(fsm_state[0]), 32'd1);
            check("en low busy", 32'(busy), 32'd1);
        end
        step();
        en = 1'b1;
        chk_rd(0, 1'b1, 2'd1, 1'b1);
        step();
        chk_rd(0, 1'b1, 2'd1, 1'b1);
        step();
        chk_rd(0, 1'b0, 2'd0, 1'b1);
        check("burst complete", 32'(fsm_state[0]), 32'd0);

        for (int c = 0; c < 3; c++) step();
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("scoreboard drained [%0d]", i), 32'(exp_q[i].size()), 32'd0);
        check("final busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/egress_read_scheduler.md
# egress_read_scheduler

Per-output read scheduler for the shared-memory switch egress stage. Each output port owns PORT_NUB per-source output FIFOs, and this block decides which source FIFO is read on each cycle. It uses a round-robin search with a burst quota, gated by downstream backpressure. It drives the switch's per-port rd_sel/rd_en, consumes the per-FIFO empty vector, and produces a valid/source strobe aligned with port_out.

## Interface
- PORT_NUB, 4: number of ports; also the number of source FIFOs per output.
- WIDTH_SEL, $clog2(PORT_NUB): width of one source index.
- BURST, 4: maximum consecutive reads from one source before the grant moves on; must be ≥1.
- RD_LAT, 1: cycles from an rd_en cycle to the matching data on port_out; must be ≥1.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global enable; low freezes all FSMs and suppresses reads.
- empty  in  PORT_NUB*PORT_NUB  bit i*PORT_NUB+j = output i, source-j FIFO empty. It reflects every read completed at earlier edges.
- tx_ready  in  PORT_NUB  downstream of output i accepts a cell this cycle.
- rd_sel  out  WIDTH_SEL*PORT_NUB  slice i = source FIFO being read at output i.
- rd_en  out  PORT_NUB  read strobe per output.
- out_vld  out  PORT_NUB  port_out slice i carries a valid cell.
- out_src  out  WIDTH_SEL*PORT_NUB  source index of the cell flagged by out_vld.
- busy  out  1  any output in SERVE, or any read still in the RD_LAT pipeline.

## Operation
Each output i has an independent FSM. Its registers are: state (IDLE/SERVE), ptr (round-robin start, WIDTH_SEL bits), src (granted source), and cnt (burst counter, $clog2(BURST+1) bits).

IDLE state:
- No read is issued.
- If en=1 and any source j of output i is non-empty, grant the first non-empty j searching ptr, ptr+1, … with modulo-PORT_NUB wrap.
- On a grant: src←j, cnt←0, state←SERVE.
- If en=0 or all sources are empty, stay in IDLE.

SERVE state:
- rd_en[i] is combinational: state==SERVE & en & tx_ready[i] & ~empty[i*PORT_NUB+src].
- rd_sel slice i = src (registered).
- At an edge where rd_en[i]=1: cnt←cnt+1. If cnt==BURST-1, exit.
- At an edge where en=1 and the src FIFO is empty: exit, with no read.
- If tx_ready[i]=0 and the FIFO is non-empty, stall: hold src, cnt and state; no exit.
- If en=0, hold everything.
- Exit action: state←IDLE, ptr←(src+1) mod PORT_NUB, cnt←0.
- A source that still holds data after its burst moves to the back of the rotation.

Read pipeline:
- An RD_LAT-deep shift register per output carries {rd_en[i], src}.
- out_vld[i] and out_src slice i are the last stage.

Reset (asynchronous, any time, including mid-burst):
- state=IDLE, ptr=0, src=0, cnt=0; all pipeline stages cleared.
- Outputs: rd_en=0, rd_sel=0, out_vld=0, out_src=0, busy=0.
- Reads already in flight are dropped; out_vld does not assert for them.

## Timing
- Grant at edge k (IDLE→SERVE). The first rd_en is possible in the cycle after edge k, and its out_vld asserts RD_LAT cycles after that rd_en cycle.
- Each source switch costs one bubble cycle in IDLE. Peak rate per output is BURST reads per BURST+1 cycles.
- There is no cross-output coupling; all outputs run concurrently.
- A single-entry FIFO is read exactly once. Its empty flag rises before the next edge, so rd_en drops in the following cycle.
- tx_ready and en act in the same cycle through combinational rd_en. There is no registered lag.
- A read on the last burst slot both counts and triggers the exit at the same edge.
- ptr wraps from PORT_NUB-1 to 0.
- BURST=1: exits after every read.

## Test plan
- Reset, then all empty=1, en=1 for 20 cycles → rd_en=0, out_vld=0, busy=0, every FSM stays in IDLE.
- Output 0: source 2 holds 6 cells, others empty, tx_ready=1 → 4 reads with rd_sel=2, 1 IDLE bubble, 2 more reads. out_vld follows each rd_en 1 cycle later with out_src=2. ptr ends at 3.
- Output 1: sources 0, 1, 3 each hold 8 cells → grants rotate 0,1,3,0,1,3, each a 4-read burst separated by 1 bubble. Source 2 is never selected.
- Output 2: source 1 has 3 cells, tx_ready toggles 1,0,0,1,1 → rd_en only in tx_ready=1 cycles, cnt holds while stalled. After the 3rd read, empty=1 causes an exit with ptr=2 and no fourth read.
- Assert rst_n=0 mid-burst (cnt=2) with a read in the pipeline → all outputs 0 asynchronously and the pending out_vld is dropped. After release, grant restarts searching from ptr=0.
- en deasserted for 3 cycles mid-burst → no rd_en, state/cnt/src held. On en=1 the burst resumes and completes its remaining reads.
